// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock / core reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int LOSS_CNT_W = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_reset_seq_sync_bit.sv
// Multi-flop synchronizer bringing a single asynchronous level into the clk domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualifier: stable-lock timer, core reset hold, pixel clock-enable divider.
// Optional lock-loss event counter enabled by defining LOCK_LOSS_CNT_EN.
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int RESET_CYCLES  = 64,
  parameter int CE_DIV        = 4
) (
  input  logic                      clk_sys,
  input  logic                      rst,
  input  logic                      pll_locked,
  input  logic                      soft_reset,
  output logic                      reset_out,
  output logic                      ready,
  output logic                      ce_pix,
  output logic [$clog2(CE_DIV)-1:0] ce_phase,
  output logic [1:0]                seq_state,
  output logic [LOSS_CNT_W-1:0]     loss_count
);

  localparam int MAX_CYC = max2(STABLE_CYCLES, RESET_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int PH_W    = $clog2(CE_DIV);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(CE_DIV - 1);
  localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);

  logic             lock_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             ce_q, ce_d;
  logic             reset_q, reset_d;
  logic             ready_q, ready_d;
  logic             lost;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk_sys),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (lock_s)
  );

  // Lock loss is checked first in every state so it outranks soft_reset and terminal counts.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    lost    = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          lost    = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          lost    = 1'b1;
        end else if (cnt_q == RESET_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          lost    = 1'b1;
        end else if (soft_reset) begin
          state_d = HOLD;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Divider restarts on every HOLD entry so the first RUN cycle lands on a known phase.
  always_comb begin
    phase_d = phase_q + PH_ONE;
    if ((state_d == WAIT_LOCK) || (state_d == STABLE) ||
        ((state_d == HOLD) && (state_q != HOLD))) begin
      phase_d = '0;
    end else if (phase_q == PH_LAST) begin
      phase_d = '0;
    end
    ce_d    = (phase_d == PH_LAST);
    reset_d = (state_d != RUN);
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      phase_q <= '0;
      ce_q    <= 1'b0;
      reset_q <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ce_q    <= ce_d;
      reset_q <= reset_d;
      ready_q <= ready_d;
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (lost && (loss_q != {LOSS_CNT_W{1'b1}})) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign loss_count = loss_q;
`else
  logic unused_lost;
  assign unused_lost = lost;
  assign loss_count  = '0;
`endif

  assign reset_out = reset_q;
  assign ready     = ready_q;
  assign ce_pix    = ce_q;
  assign ce_phase  = phase_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench for pll_lock_reset_seq with SYNC_STAGES=2, STABLE_CYCLES=16, RESET_CYCLES=8, CE_DIV=4.
`timescale 1ns/1ps
module tb_pll_lock_reset_seq;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       soft_reset;
  logic       reset_out;
  logic       ready;
  logic       ce_pix;
  logic [1:0] ce_phase;
  logic [1:0] seq_state;
  logic [7:0] loss_count;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  logic [7:0] exp_loss = 8'd0;

  typedef struct {
    int         e;
    logic [1:0] st;
    logic       ro;
    logic       rdy;
    logic       ph_en;
    logic       ce;
    logic [1:0] ph;
    logic [7:0] loss;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [1:0] S_WAIT = 2'd0, S_STABLE = 2'd1, S_HOLD = 2'd2, S_RUN = 2'd3;

  pll_lock_reset_seq #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (16),
    .RESET_CYCLES  (8),
    .CE_DIV        (4)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .pll_locked (pll_locked),
    .soft_reset (soft_reset),
    .reset_out  (reset_out),
    .ready      (ready),
    .ce_pix     (ce_pix),
    .ce_phase   (ce_phase),
    .seq_state  (seq_state),
    .loss_count (loss_count)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) edge_n <= edge_n + 1;

  function automatic logic [7:0] loss_exp();
`ifdef LOCK_LOSS_CNT_EN
    return exp_loss;
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string name, input int e, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", name, e, got, want);
    end
  endtask

  task automatic expect_at(input int e, input logic [1:0] st, input logic ro, input logic rdy,
                           input logic ph_en, input logic ce, input logic [1:0] ph);
    exp_t x;
    x.e = e; x.st = st; x.ro = ro; x.rdy = rdy;
    x.ph_en = ph_en; x.ce = ce; x.ph = ph; x.loss = loss_exp();
    sb_q.push_back(x);
  endtask

  task automatic goto_edge(input int e);
    while (edge_n < e) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},     edge_n, 32'(seq_state),  32'(S_WAIT));
    chk({tag, "_reset_out"}, edge_n, 32'(reset_out),  32'd1);
    chk({tag, "_ready"},     edge_n, 32'(ready),      32'd0);
    chk({tag, "_ce_pix"},    edge_n, 32'(ce_pix),     32'd0);
    chk({tag, "_ce_phase"},  edge_n, 32'(ce_phase),   32'd0);
    chk({tag, "_loss"},      edge_n, 32'(loss_count), 32'd0);
  endtask

  always @(negedge clk_sys) begin : monitor
    exp_t x;
    while (sb_q.size() > 0 && sb_q[0].e < edge_n) begin
      checks++;
      failures++;
      $display("FAIL sb_missed edge=%0d now=%0d", sb_q[0].e, edge_n);
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && sb_q[0].e == edge_n) begin
      x = sb_q.pop_front();
      chk("state",     x.e, 32'(seq_state),  32'(x.st));
      chk("reset_out", x.e, 32'(reset_out),  32'(x.ro));
      chk("ready",     x.e, 32'(ready),      32'(x.rdy));
      chk("loss",      x.e, 32'(loss_count), 32'(x.loss));
      if (x.ph_en) begin
        chk("ce_pix",   x.e, 32'(ce_pix),   32'(x.ce));
        chk("ce_phase", x.e, 32'(ce_phase), 32'(x.ph));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog edge=%0d got=running want=finished", edge_n);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int b, c, d;
    rst = 1'b1; pll_locked = 1'b0; soft_reset = 1'b0;
    #1;
    chk_reset_vals("por");
    repeat (3) @(posedge clk_sys);
    #1;
    rst = 1'b0;

    // Idle with no lock: stays in WAIT_LOCK
    b = edge_n;
    expect_at(b + 2, S_WAIT, 1, 0, 1, 0, 2'd0);
    expect_at(b + 4, S_WAIT, 1, 0, 1, 0, 2'd0);
    goto_edge(b + 4);

    // Lock raised after edge b: STABLE at b+3, HOLD at b+19, RUN at b+27
    b = edge_n;
    pll_locked = 1'b1;
    expect_at(b + 2,  S_WAIT,   1, 0, 1, 0, 2'd0);
    expect_at(b + 3,  S_STABLE, 1, 0, 1, 0, 2'd0);
    expect_at(b + 18, S_STABLE, 1, 0, 1, 0, 2'd0);
    expect_at(b + 19, S_HOLD,   1, 0, 1, 0, 2'd0);
    expect_at(b + 22, S_HOLD,   1, 0, 1, 1, 2'd3);
    expect_at(b + 23, S_HOLD,   1, 0, 1, 0, 2'd0);
    expect_at(b + 26, S_HOLD,   1, 0, 1, 1, 2'd3);
    expect_at(b + 27, S_RUN,    0, 1, 1, 0, 2'd0);
    expect_at(b + 30, S_RUN,    0, 1, 1, 1, 2'd3);
    goto_edge(b + 31);

    // Lock loss in RUN: back to reset 3 edges later
    b = edge_n;
    pll_locked = 1'b0;
    expect_at(b + 2, S_RUN, 0, 1, 0, 0, 2'd0);
    exp_loss++;
    expect_at(b + 3, S_WAIT, 1, 0, 1, 0, 2'd0);
    goto_edge(b + 5);

    // 3-cycle lock dropout during STABLE restarts the whole sequence
    b = edge_n;
    pll_locked = 1'b1;
    expect_at(b + 3,  S_STABLE, 1, 0, 1, 0, 2'd0);
    expect_at(b + 12, S_STABLE, 1, 0, 1, 0, 2'd0);
    exp_loss++;
    expect_at(b + 13, S_WAIT,   1, 0, 1, 0, 2'd0);
    expect_at(b + 15, S_WAIT,   1, 0, 1, 0, 2'd0);
    expect_at(b + 16, S_STABLE, 1, 0, 1, 0, 2'd0);
    expect_at(b + 31, S_STABLE, 1, 0, 1, 0, 2'd0);
    expect_at(b + 32, S_HOLD,   1, 0, 1, 0, 2'd0);
    expect_at(b + 35, S_HOLD,   1, 0, 1, 1, 2'd3);
    expect_at(b + 39, S_HOLD,   1, 0, 1, 1, 2'd3);
    expect_at(b + 40, S_RUN,    0, 1, 1, 0, 2'd0);
    goto_edge(b + 10);
    pll_locked = 1'b0;
    goto_edge(b + 13);
    pll_locked = 1'b1;
    goto_edge(b + 41);

    // Soft reset in RUN: exactly 8 cycles of HOLD, divider restarts
    c = edge_n;
    soft_reset = 1'b1;
    expect_at(c + 1,  S_HOLD, 1, 0, 1, 0, 2'd0);
    expect_at(c + 4,  S_HOLD, 1, 0, 1, 1, 2'd3);
    expect_at(c + 8,  S_HOLD, 1, 0, 1, 1, 2'd3);
    expect_at(c + 9,  S_RUN,  0, 1, 1, 0, 2'd0);
    expect_at(c + 12, S_RUN,  0, 1, 1, 1, 2'd3);
    goto_edge(c + 1);
    soft_reset = 1'b0;
    goto_edge(c + 13);

    // soft_reset presented in the same cycle the synced lock reads 0: lock loss wins
    d = edge_n;
    pll_locked = 1'b0;
    expect_at(d + 2, S_RUN, 0, 1, 0, 0, 2'd0);
    exp_loss++;
    expect_at(d + 3,  S_WAIT,   1, 0, 1, 0, 2'd0);
    expect_at(d + 4,  S_WAIT,   1, 0, 1, 0, 2'd0);
    expect_at(d + 6,  S_STABLE, 1, 0, 1, 0, 2'd0);
    expect_at(d + 10, S_STABLE, 1, 0, 1, 0, 2'd0);
    expect_at(d + 21, S_STABLE, 1, 0, 1, 0, 2'd0);
    expect_at(d + 22, S_HOLD,   1, 0, 1, 0, 2'd0);
    expect_at(d + 24, S_HOLD,   1, 0, 1, 0, 2'd2);
    goto_edge(d + 2);
    soft_reset = 1'b1;
    goto_edge(d + 3);
    soft_reset = 1'b0;
    pll_locked = 1'b1;
    // soft_reset in STABLE must be ignored
    goto_edge(d + 8);
    soft_reset = 1'b1;
    goto_edge(d + 9);
    soft_reset = 1'b0;
    goto_edge(d + 25);

    // Asynchronous reset mid-HOLD, checked between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    exp_loss = 8'd0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk_reset_vals("rst_held");
    rst = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
